// File: rtl/alu_if.sv
// Request/response handshake bundle between the issue stage and the multicycle ALU.
interface alu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle logic/arith ops, bit-serial shifts (1 bit/cycle),
// valid/ready on both sides, one operation in flight.
module multicycle_alu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic [SHW-1:0]  shamt_c;
  logic            is_shift_c;
  logic [XLEN-1:0] single_res_c;
  logic [XLEN-1:0] acc_next_c;

  assign shamt_c    = bus.operand_b[SHW-1:0];
  assign is_shift_c = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                      (bus.alu_control == OP_SRA);

  // One-cycle result; shift codes land here only when the shift amount is zero.
  always_comb begin
    single_res_c = '0;
    case (bus.alu_control)
      OP_AND:  single_res_c = bus.operand_a & bus.operand_b;
      OP_OR:   single_res_c = bus.operand_a | bus.operand_b;
      OP_ADD:  single_res_c = bus.operand_a + bus.operand_b;
      OP_SUB:  single_res_c = bus.operand_a - bus.operand_b;
      OP_SLT:  single_res_c = XLEN'($signed(bus.operand_a) < $signed(bus.operand_b));
      OP_SLTU: single_res_c = XLEN'(bus.operand_a < bus.operand_b);
      OP_XOR:  single_res_c = bus.operand_a ^ bus.operand_b;
      OP_SLL, OP_SRL, OP_SRA: single_res_c = bus.operand_a;
      default: single_res_c = '0;
    endcase
  end

  // Single-bit step of the serial shifter, selected by the captured opcode.
  always_comb begin
    acc_next_c = acc;
    case (op_q)
      OP_SLL:  acc_next_c = {acc[XLEN-2:0], 1'b0};
      OP_SRL:  acc_next_c = {1'b0, acc[XLEN-1:1]};
      OP_SRA:  acc_next_c = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_next_c = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.alu_control;
            in_ready_q <= 1'b0;
            if (is_shift_c && (shamt_c != '0)) begin
              acc   <= bus.operand_a;
              cnt   <= shamt_c;
              state <= SHIFT;
            end else begin
              result_q    <= single_res_c;
              zero_q      <= (single_res_c == '0);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next_c;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result_q    <= acc_next_c;
            zero_q      <= (acc_next_c == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_multicycle_alu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_if #(.XLEN(32)) bus ();

  multicycle_alu #(.XLEN(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a + b;
      3: return a << sh;
      4: return a >> sh;
      5: return 32'($signed(a) >>> sh);
      6: return a - b;
      7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      8: return (a < b) ? 32'd1 : 32'd0;
      9: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int model_lat(input int op, input logic [31:0] b);
    if ((op >= 3) && (op <= 5) && (b[4:0] != 5'd0)) return int'(b[4:0]);
    return 0;
  endfunction

  // Drive one request, scramble inputs after accept, wait (bounded) for out_valid.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int edges);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.alu_control = 4'(op);
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'($urandom);
    bus.operand_a   = $urandom;
    bus.operand_b   = $urandom;
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    res = bus.result;
    z   = bus.zero;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b result=%h zero=%b in_ready=%b, required 0/00000000/1/1",
               bus.out_valid, bus.result, bus.zero, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    int          op[10];
    logic [31:0] av[10];
    logic [31:0] bv[10];
    logic [31:0] ev[10];
    int          lv[10];
    logic [31:0] res;
    logic        z;
    int          edges;
    op = '{2, 6, 6, 7, 8, 5, 4, 3, 10, 15};
    av = '{32'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd1, 32'hDEADBEEF, 32'h1};
    bv = '{32'd7, 32'h1234, 32'd1, 32'd1, 32'd1, 32'd4, 32'd4, 32'd31, 32'h5, 32'h1};
    ev = '{32'd12, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hF8000000, 32'h08000000, 32'h80000000, 32'd0, 32'd0};
    lv = '{0, 0, 0, 0, 0, 4, 4, 31, 0, 0};
    for (int i = 0; i < 10; i++) begin
      run_op(op[i], av[i], bv[i], res, z, edges);
      n_checks++;
      if (res !== ev[i] || z !== (ev[i] == 32'd0) || edges !== lv[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%0d: result=%h zero=%b lat=%0d, required %h/%b/%0d",
                 i, op[i], res, z, edges, ev[i], (ev[i] == 32'd0), lv[i]);
      end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [31:0] a;
    logic [31:0] res;
    logic        z;
    int          edges;
    a = $urandom | 32'h1;
    run_op(3, a, 32'h20, res, z, edges);
    n_checks++;
    if (res !== a || edges !== 0) begin
      n_fail++;
      $display("FAIL sll_shamt0: result=%h lat=%0d, required %h/0", res, edges, a);
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid    = 1'b1;
      bus.alu_control = 4'd2;
      bus.operand_a   = $urandom;
      bus.operand_b   = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== a || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: out_valid=%b result=%h in_ready=%b, required 1/%h/0",
                 i, bus.out_valid, bus.result, bus.in_ready, a);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== a) begin
      n_fail++;
      $display("FAIL release: out_valid=%b in_ready=%b result=%h, required 0/1/%h",
               bus.out_valid, bus.in_ready, bus.result, a);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    logic        z;
    int          edges;
    bus.alu_control = 4'd5;
    bus.operand_a   = 32'h80000000;
    bus.operand_b   = 32'd20;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b result=%h zero=%b, required 0/00000000/1",
               bus.out_valid, bus.result, bus.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    run_op(2, 32'd2, 32'd2, res, z, edges);
    n_checks++;
    if (res !== 32'd4 || z !== 1'b0 || edges !== 0) begin
      n_fail++;
      $display("FAIL add_after_reset: result=%h zero=%b lat=%0d, required 00000004/0/0", res, z, edges);
    end
    consume();
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [31:0] res;
    logic        z;
    int          edges;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = a;
      if (i % 7 == 0) a = 32'd0;
      exp = model_res(op, a, b);
      run_op(op, a, b, res, z, edges);
      n_checks++;
      if (res !== exp || z !== (exp == 32'd0) || edges !== model_lat(op, b)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h zero=%b lat=%0d, required %h/%b/%0d",
                 i, op, a, b, res, z, edges, exp, (exp == 32'd0), model_lat(op, b));
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [31:0] res;
    logic        z;
    int          edges;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a   = $urandom;
      b   = $urandom;
      exp = model_res(i % 10, a, b);
      run_op(i % 10, a, b, res, z, edges);
      n_checks++;
      if (res !== exp || edges !== model_lat(i % 10, b)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: result=%h lat=%0d, required %h/%0d", i, res, edges, exp, model_lat(i % 10, b));
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b out_valid=%b, required 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'd0;
    bus.operand_a   = 32'd0;
    bus.operand_b   = 32'd0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_hold();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
